img2col_window_reader: RTL and testbench
========================================

# img2col_window_reader

Consumer-side companion to the img2col mapping controller. It accepts a raster-order pixel stream into a K-row circular line buffer, then emits one flattened K×K convolution window per cycle to the PU/systolic array over a valid/ready handshake. It walks output rows 0..OUT_H-1 and output columns 0..OUT_W-1, which are the same round/PU sequence the controller drives. It refills one image row between output rows.

## Interface
- DW, 8: pixel width in bits
- IMG_W, 32: image width in pixels
- IMG_H, 32: image height in pixels
- K, 5: kernel size
- OUT_W / OUT_H: derived localparams, IMG_W-K+1 and IMG_H-K+1 (28 each by default)

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE
- pix_valid  in  1  pixel available
- pix_data  in  DW  pixel, raster order (row-major, left to right)
- pix_ready  out  1  high in FILL and REFILL only
- win_valid  out  1  window available; high in STREAM only
- win_data  out  K*K*DW  window; slice (i*K+j)*DW +: DW is image pixel (row+i, col+j)
- win_ready  in  1  downstream accepts the window
- win_col  out  6  current output column, 0..OUT_W-1
- win_row  out  6  current output row, 0..OUT_H-1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of the frame

## Operation
- Storage: K×IMG_W pixel registers (line slots 0..K-1) and a top-slot pointer `top` (0..K-1). This storage is not reset.
- States: IDLE, FILL, STREAM, REFILL, DONE.
- IDLE: all counters are zero. If start=1, go to FILL.
- FILL: accept pixels when pix_valid&pix_ready.
  - Write order: slot = pixel index / IMG_W, column = pixel index mod IMG_W.
  - After K*IMG_W accepted pixels (160 by default), go to STREAM with top=0, win_row=0, win_col=0.
- STREAM: win_valid=1.
  - win_data is assembled combinationally from slots (top+i) mod K, columns win_col+j.
  - On handshake (win_valid&win_ready):
    - if win_col<OUT_W-1: win_col+1
    - else if win_row=OUT_H-1: go to DONE
    - else: win_col=0, go to REFILL
- REFILL: accept IMG_W pixels into slot `top`, columns 0..IMG_W-1.
  - On the last accepted pixel: top=(top+1) mod K, win_row+1, go to STREAM.
- DONE: done=1 for one cycle, then go to IDLE. win_row and win_col return to 0.
- start is ignored outside IDLE.
- Pixels presented while pix_ready=0 are not consumed.
- Counter widths:
  - pixel counter ceil(log2(K*IMG_W+1)) bits
  - win_col and win_row are 6 bits
  - top wraps explicitly at K; it never relies on power-of-two overflow

## Timing
- Reset values: pix_ready=0, win_valid=0, win_data=0 (gated while win_valid=0), win_col=0, win_row=0, busy=0, done=0, state=IDLE, top=0.
- Start latency: start high at edge n puts FILL active and pix_ready=1 in cycle n+1.
- FILL/REFILL to STREAM: the cycle after the last pixel handshake, win_valid=1 with column 0 of the new row.
- Window throughput: one window per cycle while win_ready=1.
- Stalls: while win_ready=0, win_data, win_col and win_row are held stable.
- Buffer write timing: a slot is only written in FILL and REFILL, so win_data never changes under a stalled window.
- End of frame: the last window handshake at edge m gives done=1 in cycle m+1 and busy=0 in cycle m+2.
- Frame size: one frame accepts IMG_W*IMG_H pixels (1024) and emits OUT_W*OUT_H windows (784).
- Reset mid-operation: the block returns to IDLE immediately and all outputs take their reset values. Any partial frame is discarded; the next start reloads from pixel 0.
- Simultaneous events: start in the same cycle as done is ignored, since the block is not yet in IDLE.

## Test plan
- Ramp frame, where pix_data = (r*IMG_W+c) mod 256, with always-ready handshakes:
  - the first window row 0 / col 0 has slice (i,j) = i*32+j;
  - window (27,27) has slice (0,0)=(27*32+27) mod 256=123;
  - exactly 784 windows are emitted, then done pulses once.
- Top-pointer wrap: after 5 refills (win_row=5), top=0 again and window (5,0) slice (0,0)=160 mod 256=160.
- Backpressure: toggle win_ready randomly.
  - win_data, win_col and win_row stay stable while the window is stalled.
  - No window is skipped or duplicated: the sequence matches the always-ready run.
- Input gaps: deassert pix_valid randomly during FILL and REFILL. The accepted pixel count stays 1024 and the windows are unchanged.
- Assert rst at the 100th window. Outputs go to zero and the state to IDLE; a new start followed by a full frame produces correct windows from (0,0).
- Pulse start during STREAM and in the done cycle. Neither has any effect; only a start in IDLE begins a new frame.

Source files
------------

// File: rtl/img2col_window_reader.sv
// K-row circular line buffer fed by a raster pixel stream; emits one flattened
// KxK window per cycle in output-row/column order, refilling one row between output rows.
module img2col_window_reader #(
  parameter int DW    = 8,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [DW-1:0]     pix_data,
  output logic              pix_ready,
  output logic              win_valid,
  output logic [K*K*DW-1:0] win_data,
  input  logic              win_ready,
  output logic [5:0]        win_col,
  output logic [5:0]        win_row,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int PCW   = $clog2(K*IMG_W+1);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [PCW-1:0] FILL_LAST = PCW'(K*IMG_W-1);
  localparam logic [PCW-1:0] ROW_LAST  = PCW'(IMG_W-1);
  localparam logic [CW-1:0]  WCOL_LAST = CW'(IMG_W-1);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(K-1);
  localparam logic [5:0]     COL_LAST  = 6'(OUT_W-1);
  localparam logic [5:0]     ROW_END   = 6'(OUT_H-1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_REFILL, S_DONE} state_t;
  state_t state, state_nxt;

  logic [PCW-1:0] pix_cnt;
  logic [CW-1:0]  wr_col;
  logic [SW-1:0]  fill_slot, top, wr_slot;
  logic [DW-1:0]  mem [K][IMG_W];
  logic [SW-1:0]  rd_slot [K];
  logic [K*K*DW-1:0] win_raw;
  logic pix_hs, win_hs, pix_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    win_valid = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && pix_cnt == FILL_LAST) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        win_valid = 1'b1;
        if (win_ready && win_col == COL_LAST)
          state_nxt = (win_row == ROW_END) ? S_DONE : S_REFILL;
      end
      S_REFILL: begin
        pix_ready = 1'b1;
        if (pix_valid && pix_cnt == ROW_LAST) state_nxt = S_STREAM;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign pix_hs   = pix_valid & pix_ready;
  assign win_hs   = win_valid & win_ready;
  assign pix_done = pix_hs && (pix_cnt == ((state == S_FILL) ? FILL_LAST : ROW_LAST));
  assign wr_slot  = (state == S_FILL) ? fill_slot : top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      wr_col    <= '0;
      fill_slot <= '0;
      top       <= '0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      case (state)
        S_FILL, S_REFILL: if (pix_hs) begin
          if (pix_done) begin
            pix_cnt   <= '0;
            wr_col    <= '0;
            fill_slot <= '0;
            // a finished refill retires the oldest row: advance the ring
            if (state == S_REFILL) begin
              top     <= (top == SLOT_LAST) ? '0 : top + SW'(1);
              win_row <= win_row + 6'd1;
            end
          end else begin
            pix_cnt <= pix_cnt + PCW'(1);
            if (wr_col == WCOL_LAST) begin
              wr_col    <= '0;
              fill_slot <= fill_slot + SW'(1);
            end else begin
              wr_col <= wr_col + CW'(1);
            end
          end
        end
        S_STREAM: if (win_hs) win_col <= (win_col == COL_LAST) ? 6'd0 : win_col + 6'd1;
        default: begin
          pix_cnt   <= '0;
          wr_col    <= '0;
          fill_slot <= '0;
          top       <= '0;
          win_col   <= '0;
          win_row   <= '0;
        end
      endcase
    end
  end

  // Line storage carries no reset; it is fully rewritten before any window reads it.
  always_ff @(posedge clk) begin
    if (pix_hs) mem[wr_slot][wr_col] <= pix_data;
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    logic [SW:0] sum;
    assign sum         = {1'b0, top} + (SW+1)'(gi);
    assign rd_slot[gi] = (sum >= (SW+1)'(K)) ? SW'(sum - (SW+1)'(K)) : SW'(sum);
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      logic [CW-1:0] rc;
      assign rc = CW'(win_col + 6'(gj));
      assign win_raw[(gi*K+gj)*DW +: DW] = mem[rd_slot[gi]][rc];
    end
  end

  assign win_data = win_valid ? win_raw : '0;

endmodule

// File: tb/tb_img2col_window_reader.sv
// Self-checking bench: windows compared against a direct image-array model,
// plus a table of hand-computed ramp-frame pixels and reset/start corner cases.
module tb_img2col_window_reader;
  localparam int DW = 8, IMG_W = 32, IMG_H = 32, K = 5;
  localparam int OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1;
  localparam int WW = K*K*DW, NPIX = IMG_W*IMG_H, NWIN = OUT_W*OUT_H;

  logic clk = 1'b0, rst, start, pix_valid, pix_ready, win_valid, win_ready, busy, done;
  logic [DW-1:0] pix_data;
  logic [WW-1:0] win_data;
  logic [5:0]    win_col, win_row;

  always #5 clk = ~clk;

  img2col_window_reader #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row), .busy(busy), .done(done)
  );

  logic [DW-1:0] img [NPIX];
  logic [WW-1:0] cap [NWIN];
  int n_pass = 0, n_tot = 0;

  typedef struct { int r; int c; int i; int j; logic [DW-1:0] exp; } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WW-1:0] model(input int r, input int c);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = img[(r+i)*IMG_W + c + j];
    return w;
  endfunction

  // mode: 0 capture windows, 1 compare against captured run, 2 model only
  task automatic run_frame(input bit gaps, input bit bp, input bit noise,
                           input int abort_at, input int mode);
    int pidx = 0, nwin = 0, er = 0, ec = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [WW-1:0] hold_d = '0;
    logic [11:0]   hold_p = '0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("start_latency", WW'({busy, pix_ready, win_valid}), WW'(3'b110));
    while (nwin < NWIN && cyc < 20000) begin
      if (stalled) begin
        chk("stall_data", win_data, hold_d);
        chk("stall_pos", WW'({win_row, win_col}), WW'(hold_p));
      end
      pix_valid = (pidx < NPIX) && (!gaps || $urandom_range(0, 2) != 0);
      pix_data  = pix_valid ? img[pidx] : DW'($urandom);
      win_ready = !bp || ($urandom_range(0, 1) == 1);
      start     = noise && ($urandom_range(0, 15) == 0);
      if (pix_valid && pix_ready) pidx++;
      stalled = win_valid && !win_ready;
      hold_d  = win_data;
      hold_p  = {win_row, win_col};
      if (win_valid && win_ready) begin
        chk("win_pos", WW'({win_row, win_col}), WW'({6'(er), 6'(ec)}));
        chk("win_data", win_data, model(er, ec));
        if (mode == 0) cap[er*OUT_W+ec] = win_data;
        else if (mode == 1) chk("vs_ready_run", win_data, cap[er*OUT_W+ec]);
        nwin++;
        if (ec == OUT_W-1) begin ec = 0; er++; end
        else ec++;
      end
      @(posedge clk); #1; cyc++;
      if (nwin == abort_at) break;
    end
    if (nwin == abort_at) begin
      rst = 1'b1; #1;
      chk("rst_ctrl", WW'({pix_ready, win_valid, busy, done, win_col, win_row}), '0);
      chk("rst_data", win_data, '0);
      @(posedge clk); #1;
      rst = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; start = 1'b0;
      chk("rst_idle", WW'({busy, pix_ready}), '0);
      return;
    end
    if (cyc >= 20000) begin
      chk("timeout_windows", WW'(nwin), WW'(NWIN));
      return;
    end
    pix_valid = 1'b0; win_ready = 1'b0;
    start = noise;  // start during the done cycle must be ignored
    chk("done_cycle", WW'({done, busy, win_valid, pix_ready}), WW'(4'b1100));
    chk("pix_count", WW'(pidx), WW'(NPIX));
    @(posedge clk); #1; start = 1'b0;
    chk("idle_after_done", WW'({done, busy, win_col, win_row}), '0);
    repeat (3) @(posedge clk);
    #1;
    chk("stays_idle", WW'({busy, pix_ready}), '0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 8'd0};
    tbl[1] = '{0, 0, 1, 3, 8'd35};
    tbl[2] = '{0, 0, 4, 4, 8'd132};
    tbl[3] = '{27, 27, 0, 0, 8'd123};
    tbl[4] = '{27, 27, 4, 4, 8'd255};
    tbl[5] = '{5, 0, 0, 0, 8'd160};
    tbl[6] = '{10, 3, 2, 1, 8'd132};

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    chk("reset_ctrl", WW'({pix_ready, win_valid, busy, done, win_col, win_row}), '0);
    chk("reset_data", win_data, '0);

    for (int p = 0; p < NPIX; p++) img[p] = DW'(p);
    run_frame(1'b0, 1'b0, 1'b0, -1, 0);
    for (int t = 0; t < 7; t++) begin
      logic [WW-1:0] w;
      w = cap[tbl[t].r*OUT_W + tbl[t].c];
      chk($sformatf("ramp_r%0d_c%0d_i%0d_j%0d", tbl[t].r, tbl[t].c, tbl[t].i, tbl[t].j),
          WW'(w[(tbl[t].i*K+tbl[t].j)*DW +: DW]), WW'(tbl[t].exp));
    end

    run_frame(1'b1, 1'b1, 1'b1, -1, 1);

    for (int p = 0; p < NPIX; p++) img[p] = DW'($urandom);
    run_frame(1'b1, 1'b1, 1'b0, 100, 2);
    run_frame(1'b1, 1'b0, 1'b0, -1, 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
